counter_run_controller: RTL and testbench
=========================================

// Module: counter_run_controller
// PURPOSE
//   Sequences the 4-bit synchronous up-counter (clear/clock/count_enable -> Q/Qbar).
//   - On a start request: clears the counter, enables it for exactly `target` counts, then stops and reports done.
//   - Supports pause and abort.
//   - Keeps a shadow count and flags any mismatch between the counter's Q and the expected value.
//   - Sits between the test/control logic and the counter instance, and owns the counter's clear and count_enable inputs.
// PARAMETERS
//   WIDTH       4   counter width; width of target, cnt_q and shadow count
//   CLR_CYCLES  2   cycles cnt_clear_n is held low in CLEAR (>=1)
// PORTS
//   clock        in   1      system clock; all state changes on posedge
//   clear        in   1      asynchronous, active-low reset
//   start        in   1      1-cycle pulse: begin a run (ignored unless IDLE or DONE)
//   target       in   WIDTH  number of counts for the run; sampled when start accepted
//   pause        in   1      level: hold count while high (RUN only)
//   abort        in   1      1-cycle pulse: end run immediately, go IDLE
//   cnt_q        in   WIDTH  Q of the controlled counter
//   cnt_clear_n  out  1      active-low clear to counter (registered)
//   cnt_enable   out  1      count_enable to counter (registered)
//   busy         out  1      high in CLEAR, RUN, PAUSE
//   done         out  1      high in DONE
//   err          out  1      sticky: cnt_q != shadow count seen; cleared on start accept
// BEHAVIOUR
//   Reset (clear=0, async): state=IDLE, cnt_clear_n=0, cnt_enable=0, busy=0, done=0, err=0, exp=0, tgt_r=0, clr_cnt=0.
//   First posedge after reset release: cnt_clear_n -> 1 in IDLE.
//   States: IDLE, CLEAR, RUN, PAUSE, DONE (encoded in package).
//   IDLE/DONE + start:
//     - tgt_r<=target, exp<=0, err<=0, clr_cnt<=0, cnt_clear_n<=0, state->CLEAR.
//     - DONE without start: holds (done=1) indefinitely.
//   CLEAR:
//     - cnt_clear_n held 0 for CLR_CYCLES cycles; then cnt_clear_n<=1.
//     - If tgt_r==0: state->DONE (zero enable cycles). Else state->RUN with cnt_enable<=1.
//   RUN:
//     - Each cycle cnt_enable==1: exp<=exp+1 (mod 2^WIDTH).
//     - cnt_enable<=0 and state->DONE on the edge where exp+1==tgt_r, so exactly tgt_r enable cycles are issued.
//     - pause=1: cnt_enable<=0, state->PAUSE (exp not incremented for that cycle if enable already low).
//   PAUSE:
//     - cnt_enable=0.
//     - pause=0: state->RUN, cnt_enable<=1 (remaining count preserved).
//   Target range: tgt_r==2^WIDTH-1 is the max run; wrap never occurs within a run.
//   Check:
//     - In RUN, PAUSE, DONE, on every posedge compare cnt_q with exp (both update on the same edge).
//     - Mismatch sets err; err stays set until the next accepted start. Not checked in IDLE/CLEAR.
//   abort (any non-IDLE state):
//     - Next state IDLE, cnt_enable<=0, cnt_clear_n<=1, exp held, err held.
//     - abort has priority over pause and start.
//   Simultaneous events:
//     - start while busy: ignored.
//     - start and abort in DONE: abort wins -> IDLE.
//     - pause on the final-count edge: run completes -> DONE.
//   Reset mid-run: all outputs go to reset values immediately (cnt_enable=0 asynchronously).
//   Latency: start -> first cnt_enable=1 is CLR_CYCLES+1 cycles; last enable -> done=1 on the next cycle.
// STRUCTURE
//   Package counter_ctrl_pkg:
//     - state enum (IDLE, CLEAR, RUN, PAUSE, DONE)
//     - default WIDTH, CLR_CYCLES constants
//   Sub-module count_checker:
//     - Holds shadow exp counter, compare and sticky err.
//     - Inputs: inc, init, check_en, cnt_q.
//   Top: FSM + clr_cnt timer + output registers.
// TESTING (bench instantiates this block + the 4-bit counter, 10-unit clock)
//   1 Reset then start, target=5, pause=0:
//       -> cnt_enable high exactly 5 cycles; done=1; cnt_q=5; err=0.
//   2 target=15 with pause high 3 cycles mid-run:
//       -> 15 enable cycles total; cnt_q frozen during pause; final cnt_q=15; done=1.
//   3 target=0:
//       -> CLEAR then DONE; cnt_enable never high; cnt_q=0; done=1.
//   4 abort at count 7 of target=12:
//       -> IDLE within 1 cycle; cnt_enable=0; cnt_q stays 7; busy=0; done=0.
//   5 Force counter Q bit0 stuck-at-0 and run target=4:
//       -> err=1 by the 2nd enable cycle; err cleared on next start.
//   6 Assert clear low mid-RUN (count 3):
//       -> cnt_enable=0 and busy=0 immediately; after release, start target=2 -> cnt_q=2, done=1.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types and defaults for the counter run controller: FSM state
// encoding, default widths and the state classification helper.
package counter_ctrl_pkg;

    localparam int unsigned CTRL_WIDTH      = 4;
    localparam int unsigned CTRL_CLR_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Q is only meaningful against the shadow count once the clear phase is over.
    function automatic logic state_checked(input state_e s);
        return (s == ST_RUN) || (s == ST_PAUSE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/count_checker.sv
// Shadow copy of the expected counter value plus a sticky mismatch flag
// comparing it against the real counter's Q.
module count_checker #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_init,
    input  logic             i_check_en,
    input  logic [WIDTH-1:0] i_cnt_q,
    output logic [WIDTH-1:0] o_exp,
    output logic             o_err
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_exp;
    logic             r_err;
    logic             w_mismatch;

    // Both sides are pre-edge values, so counter and shadow stay in lockstep.
    assign w_mismatch = i_check_en && (i_cnt_q != r_exp);

    // Shadow count and sticky error register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_exp <= '0;
            r_err <= 1'b0;
        end else if (i_init) begin
            r_exp <= '0;
            r_err <= 1'b0;
        end else begin
            r_exp <= i_inc ? (r_exp + ONE) : r_exp;
            r_err <= r_err | w_mismatch;
        end
    end

    assign o_exp = r_exp;
    assign o_err = r_err;

endmodule

// File: rtl/counter_run_controller.sv
// Sequences an external up-counter through clear / run / pause / done,
// issuing exactly `target` count enables and checking Q against a shadow count.
module counter_run_controller
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = CTRL_WIDTH,
    parameter int unsigned CLR_CYCLES = CTRL_CLR_CYCLES
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    input  logic             pause,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_clear_n,
    output logic             cnt_enable,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int unsigned       CW       = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CW-1:0]     CLR_LAST = CW'(CLR_CYCLES - 1);
    localparam logic [WIDTH-1:0]  ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0]  ZERO     = '0;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CW-1:0]    r_clr_cnt;
    logic [WIDTH-1:0] r_tgt;
    logic [WIDTH-1:0] w_exp;
    logic [WIDTH-1:0] w_exp_inc;
    logic             r_cnt_clear_n;
    logic             r_cnt_enable;
    logic             r_busy;
    logic             r_done;
    logic             w_clear_n_nxt;
    logic             w_enable_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_accept;
    logic             w_check_en;
    logic             w_clr_last;
    logic             w_run_last;
    logic             w_abort_ok;

    assign w_exp_inc  = w_exp + ONE;
    assign w_clr_last = (r_clr_cnt == CLR_LAST);
    assign w_run_last = r_cnt_enable && (w_exp_inc == r_tgt);
    assign w_abort_ok = abort && (r_state != ST_IDLE);
    assign w_accept   = (w_state_nxt == ST_CLEAR) &&
                        ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_check_en = state_checked(r_state);

    // State, timer and registered outputs.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state       <= ST_IDLE;
            r_cnt_clear_n <= 1'b0;
            r_cnt_enable  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_tgt         <= '0;
            r_clr_cnt     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt_clear_n <= w_clear_n_nxt;
            r_cnt_enable  <= w_enable_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_tgt         <= w_accept ? target : r_tgt;
            r_clr_cnt     <= ((r_state == ST_CLEAR) && (w_state_nxt == ST_CLEAR)) ?
                             (r_clr_cnt + CW'(1)) : '0;
        end
    end

    // Next-state logic; abort outranks the final count, pause and start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_CLEAR;
                else       w_state_nxt = ST_IDLE;
            end
            ST_CLEAR: begin
                if (w_abort_ok)          w_state_nxt = ST_IDLE;
                else if (!w_clr_last)    w_state_nxt = ST_CLEAR;
                else if (r_tgt == ZERO)  w_state_nxt = ST_DONE;
                else                     w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_abort_ok)      w_state_nxt = ST_IDLE;
                else if (w_run_last) w_state_nxt = ST_DONE;
                else if (pause)      w_state_nxt = ST_PAUSE;
                else                 w_state_nxt = ST_RUN;
            end
            ST_PAUSE: begin
                if (w_abort_ok) w_state_nxt = ST_IDLE;
                else if (pause) w_state_nxt = ST_PAUSE;
                else            w_state_nxt = ST_RUN;
            end
            ST_DONE: begin
                if (w_abort_ok) w_state_nxt = ST_IDLE;
                else if (start) w_state_nxt = ST_CLEAR;
                else            w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they register alongside it.
    always_comb begin
        w_clear_n_nxt = 1'b1;
        w_enable_nxt  = 1'b0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        case (w_state_nxt)
            ST_CLEAR: begin
                w_clear_n_nxt = 1'b0;
                w_busy_nxt    = 1'b1;
            end
            ST_RUN: begin
                w_enable_nxt = 1'b1;
                w_busy_nxt   = 1'b1;
            end
            ST_PAUSE: w_busy_nxt = 1'b1;
            ST_DONE:  w_done_nxt = 1'b1;
            ST_IDLE:  w_busy_nxt = 1'b0;
            default:  w_busy_nxt = 1'b0;
        endcase
    end

    count_checker #(
        .WIDTH (WIDTH)
    ) u_checker (
        .i_clk      (clock),
        .i_rst_n    (clear),
        .i_inc      (r_cnt_enable),
        .i_init     (w_accept),
        .i_check_en (w_check_en),
        .i_cnt_q    (cnt_q),
        .o_exp      (w_exp),
        .o_err      (err)
    );

    assign cnt_clear_n = r_cnt_clear_n;
    assign cnt_enable  = r_cnt_enable;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_counter_run_controller.sv
// Bench for counter_run_controller driving a behavioural 4-bit counter with an
// optional stuck-at-0 fault on Q bit 0.
module tb_counter_run_controller;

    typedef struct packed {
        logic [7:0] en;
        logic [3:0] q;
        logic       done;
        logic       err;
    } exp_t;

    logic       clock = 1'b0;
    logic       clear;
    logic       start;
    logic       pause;
    logic       abort;
    logic       stuck0;
    logic [3:0] target;
    logic [3:0] cnt_q;
    logic [3:0] r_cnt;
    logic       cnt_clear_n;
    logic       cnt_enable;
    logic       busy;
    logic       done;
    logic       err;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    counter_run_controller #(
        .WIDTH      (4),
        .CLR_CYCLES (2)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .target      (target),
        .pause       (pause),
        .abort       (abort),
        .cnt_q       (cnt_q),
        .cnt_clear_n (cnt_clear_n),
        .cnt_enable  (cnt_enable),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clock = ~clock;

    // Behavioural synchronous up-counter with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!cnt_clear_n)    r_cnt <= 4'd0;
        else if (cnt_enable) r_cnt <= r_cnt + 4'd1;
    end
    assign cnt_q = stuck0 ? (r_cnt & 4'b1110) : r_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input int en, input logic [3:0] q, input logic d, input logic e);
        exp_t x;
        x.en   = 8'(en);
        x.q    = q;
        x.done = d;
        x.err  = e;
        sb_q.push_back(x);
    endtask

    task automatic start_run(input logic [3:0] tgt);
        target = tgt;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check_val("start_busy", busy, 1);
        check_val("start_clear_n", cnt_clear_n, 0);
        check_val("start_err_clr", err, 0);
    endtask

    // Step until done, counting enables, optionally pausing and probing err.
    task automatic finish_run(input int pause_at, input int pause_len, input int err_by);
        int   n_en = 0;
        int   n_p = 0;
        int   cyc = 0;
        logic prev_en = 1'b1;
        logic [3:0] q_prev = 4'd0;
        bit   err_seen = 1'b0;
        exp_t x;
        while (!done && cyc < 100) begin
            if (n_en > 0 && !prev_en && busy) check_val("q_frozen", cnt_q, q_prev);
            if (cnt_enable) n_en++;
            prev_en = cnt_enable;
            q_prev  = cnt_q;
            if (pause_len > 0 && n_en >= pause_at && n_p < pause_len) begin
                pause = 1'b1;
                n_p++;
            end else begin
                pause = 1'b0;
            end
            tick();
            cyc++;
            if (err_by > 0 && n_en == err_by && !err_seen) begin
                check_val("err_by_2nd", err, 1);
                err_seen = 1'b1;
            end
        end
        pause = 1'b0;
        check_val("done_timeout", done, 1);
        x = sb_q.pop_front();
        check_val("enables", n_en, x.en);
        check_val("final_q", cnt_q, x.q);
        check_val("final_done", done, x.done);
        check_val("final_err", err, x.err);
        check_val("final_busy", busy, 0);
        check_val("final_en", cnt_enable, 0);
    endtask

    task automatic wait_q(input logic [3:0] q);
        int cyc = 0;
        while (cnt_q != q && cyc < 100) begin
            tick();
            cyc++;
        end
        check_val("wait_q", cnt_q, q);
    endtask

    initial begin
        exp_t x;
        start = 1'b0; pause = 1'b0; abort = 1'b0; stuck0 = 1'b0; target = 4'd0;
        clear = 1'b1;
        #2 clear = 1'b0;
        #1;
        check_val("rst_clear_n", cnt_clear_n, 0);
        check_val("rst_en", cnt_enable, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        repeat (3) tick();
        clear = 1'b1;
        tick();
        check_val("idle_clear_n", cnt_clear_n, 1);

        // 1: plain run of 5
        push_exp(5, 4'd5, 1'b1, 1'b0);
        start_run(4'd5);
        finish_run(0, 0, 0);

        // 2: full-range run with a 3-cycle pause after the 7th enable
        push_exp(15, 4'd15, 1'b1, 1'b0);
        start_run(4'd15);
        finish_run(7, 3, 0);

        // 3: zero-length run
        push_exp(0, 4'd0, 1'b1, 1'b0);
        start_run(4'd0);
        finish_run(0, 0, 0);

        // 4: abort sampled on the edge that brings Q to 7
        push_exp(7, 4'd7, 1'b0, 1'b0);
        start_run(4'd12);
        wait_q(4'd6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_en", cnt_enable, 0);
        check_val("abort_clear_n", cnt_clear_n, 1);
        repeat (3) tick();
        x = sb_q.pop_front();
        check_val("abort_q", cnt_q, x.q);
        check_val("abort_idle_done", done, x.done);

        // 5: Q bit0 stuck at 0
        stuck0 = 1'b1;
        push_exp(4, 4'd4, 1'b1, 1'b1);
        start_run(4'd4);
        finish_run(0, 0, 2);
        stuck0 = 1'b0;
        push_exp(3, 4'd3, 1'b1, 1'b0);
        start_run(4'd3);
        finish_run(0, 0, 0);

        // 6: reset asserted mid-run
        start_run(4'd9);
        wait_q(4'd3);
        clear = 1'b0;
        #1;
        check_val("mid_rst_en", cnt_enable, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_clear_n", cnt_clear_n, 0);
        tick();
        tick();
        clear = 1'b1;
        tick();
        check_val("post_rst_clear_n", cnt_clear_n, 1);
        push_exp(2, 4'd2, 1'b1, 1'b0);
        start_run(4'd2);
        finish_run(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
